// File: rtl/rca_pipe_nbit.sv
// Pipelined N-bit ripple-carry add/subtract: the carry chain is cut into STAGES
// equal segments, one segment resolved per cycle, with valid/ready flow control.
module rca_pipe_nbit #(
    parameter int N      = 64,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_a,
    input  logic [N-1:0]     i_b,
    input  logic             i_c,
    input  logic             i_sub,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_s,
    output logic             o_c,
    output logic             o_ovf,
    output logic [TAG_W-1:0] o_tag
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    generate
        if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
            $error("rca_pipe_nbit: N must be a multiple of STAGES and 1 <= STAGES <= N");
        end
    endgenerate

    // One segment of the ripple chain; returns {ovf, carry_out, sum}.
    function automatic logic [W+1:0] ripple_seg(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         cin);
        logic [W:0]   c;
        logic [W-1:0] s;
        logic         g;
        logic         p;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            g      = a[i] & b[i];
            p      = a[i] ^ b[i];
            s[i]   = p ^ c[i];
            c[i+1] = g | (p & c[i]);
        end
        return {c[W] ^ c[W-1], c[W], s};
    endfunction

    // Resolved sum bits enter at the top and slide down W bits per stage, so
    // after the last stage every segment sits at its final position.
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] acc,
                                              input logic [W-1:0] seg);
        logic [N-1:0] r;
        r           = acc >> W;
        r[N-1 -: W] = seg;
        return r;
    endfunction

    // Per-stage registers; a_p/b_p hold the still-unresolved operand bits,
    // pre-shifted so the next segment is always in the low W bits.
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] c_p;
    logic [STAGES-1:0] ovf_p;
    logic [N-1:0]      a_p   [STAGES];
    logic [N-1:0]      b_p   [STAGES];
    logic [N-1:0]      s_p   [STAGES];
    logic [TAG_W-1:0]  tag_p [STAGES];

    logic [STAGES:0]   take;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_c;
    logic [N-1:0]      src_a   [STAGES];
    logic [N-1:0]      src_b   [STAGES];
    logic [N-1:0]      src_s   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [N-1:0]      a_nx    [STAGES];
    logic [N-1:0]      b_nx    [STAGES];
    logic [N-1:0]      s_nx    [STAGES];
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] ovf_nx;

    // take[k]: stage k loads this cycle (empty, or its content moves on).
    always_comb begin
        take         = '0;
        adv          = '0;
        take[STAGES] = i_ready;
        for (int k = L; k >= 0; k--) begin
            adv[k]  = vld_p[k] & take[k+1];
            take[k] = ~vld_p[k] | adv[k];
        end
    end

    always_comb begin
        logic [W+1:0] seg;
        seg        = '0;
        src_vld    = vld_p << 1;
        src_vld[0] = i_valid;
        src_a[0]   = i_a;
        src_b[0]   = i_b ^ {N{i_sub}};
        src_s[0]   = '0;
        src_c      = c_p << 1;
        src_c[0]   = i_c ^ i_sub;
        src_tag[0] = i_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_p[k-1];
            src_b[k]   = b_p[k-1];
            src_s[k]   = s_p[k-1];
            src_tag[k] = tag_p[k-1];
        end
        c_nx   = '0;
        ovf_nx = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg       = ripple_seg(src_a[k][W-1:0], src_b[k][W-1:0], src_c[k]);
            a_nx[k]   = src_a[k] >> W;
            b_nx[k]   = src_b[k] >> W;
            s_nx[k]   = shift_in(src_s[k], seg[W-1:0]);
            c_nx[k]   = seg[W];
            ovf_nx[k] = seg[W+1];
        end
    end

    // Stage boundary: every segment registers here, the last one feeds the outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p <= '0;
            c_p   <= '0;
            ovf_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                tag_p[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) begin
                    vld_p[k] <= src_vld[k];
                end
                // Data only loads with a real op so idle outputs keep their last values.
                if (take[k] && src_vld[k]) begin
                    a_p[k]   <= a_nx[k];
                    b_p[k]   <= b_nx[k];
                    s_p[k]   <= s_nx[k];
                    c_p[k]   <= c_nx[k];
                    ovf_p[k] <= ovf_nx[k];
                    tag_p[k] <= src_tag[k];
                end
            end
        end
    end

    assign o_ready = take[0];
    assign o_valid = vld_p[L];
    assign o_s     = s_p[L];
    assign o_c     = c_p[L];
    assign o_ovf   = ovf_p[L];
    assign o_tag   = tag_p[L];

endmodule

// File: tb/tb_rca_pipe_nbit.sv
// Scoreboard bench for rca_pipe_nbit: 64-bit/4-stage main instance plus two
// 8-bit instances (1 and 8 stages) for latency and carry corner cases.
module tb_rca_pipe_nbit;

    localparam int N  = 64;
    localparam int ST = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
        logic [3:0]  tag;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, o_ready, i_c, i_sub, o_valid, i_ready, o_c, o_ovf;
    logic [N-1:0]  i_a, i_b, o_s;
    logic [TW-1:0] i_tag, o_tag;

    logic          v8, rdy8, c8, sub8;
    logic [7:0]    a8, b8;
    logic [3:0]    tag8;
    logic          rdy_s1, vld_s1, c_s1, ovf_s1, rdy_s8, vld_s8, c_s8, ovf_s8;
    logic [7:0]    s_s1, s_s8;
    logic [3:0]    tag_s1, tag_s8;

    int   n_err = 0;
    int   n_chk = 0;
    int   n_pop = 0;
    res_t q[$];
    bit   rnd_rdy = 1'b0;
    logic stalled = 1'b0;
    res_t held;

    always #5 clk = ~clk;

    rca_pipe_nbit #(.N(N), .STAGES(ST), .TAG_W(TW)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_c(o_c),
        .o_ovf(o_ovf), .o_tag(o_tag)
    );

    rca_pipe_nbit #(.N(8), .STAGES(1), .TAG_W(4)) u_s1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy_s1),
        .i_a(a8), .i_b(b8), .i_c(c8), .i_sub(sub8), .i_tag(tag8),
        .o_valid(vld_s1), .i_ready(rdy8), .o_s(s_s1), .o_c(c_s1),
        .o_ovf(ovf_s1), .o_tag(tag_s1)
    );

    rca_pipe_nbit #(.N(8), .STAGES(8), .TAG_W(4)) u_s8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy_s8),
        .i_a(a8), .i_b(b8), .i_c(c8), .i_sub(sub8), .i_tag(tag8),
        .o_valid(vld_s8), .i_ready(rdy8), .o_s(s_s8), .o_c(c_s8),
        .o_ovf(ovf_s8), .o_tag(tag_s8)
    );

    // Reference: exact integer arithmetic at width n.
    function automatic res_t ref_op(input logic [63:0] a, input logic [63:0] b,
                                    input logic c, input logic sub,
                                    input logic [3:0] tag, input int n);
        logic [63:0]        mask;
        logic [64:0]        ua, ub, uc, ures;
        logic signed [66:0] sa, sb, sc, sr, lim;
        res_t               r;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        ua   = {1'b0, a & mask};
        ub   = {1'b0, b & mask};
        uc   = {64'd0, c};
        sa   = $signed({3'b000, a & mask});
        sb   = $signed({3'b000, b & mask});
        if (a[n-1]) sa = sa - (67'sd1 <<< n);
        if (b[n-1]) sb = sb - (67'sd1 <<< n);
        sc   = $signed({66'd0, c});
        lim  = 67'sd1 <<< (n - 1);
        ures = '0;
        if (sub) begin
            sr  = sa - sb - sc;
            r.c = (ua >= ub + uc);
        end else begin
            sr   = sa + sb + sc;
            ures = ua + ub + uc;
            r.c  = ures[n];
        end
        r.s   = sr[63:0] & mask;
        r.ovf = (sr >= lim) || (sr < -lim);
        r.tag = tag;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_s", o_s, held.s);
                chk("hold_c", 64'(o_c), 64'(held.c));
                chk("hold_ovf", 64'(o_ovf), 64'(held.ovf));
                chk("hold_tag", 64'(o_tag), 64'(held.tag));
            end
            if (o_valid && i_ready) begin
                n_pop++;
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(o_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("s", o_s, e.s);
                    chk("c", 64'(o_c), 64'(e.c));
                    chk("ovf", 64'(o_ovf), 64'(e.ovf));
                    chk("tag", 64'(o_tag), 64'(e.tag));
                end
            end
            if (i_valid && o_ready) q.push_back(ref_op(i_a, i_b, i_c, i_sub, i_tag, N));
            stalled  = o_valid && !i_ready;
            held.s   = o_s;
            held.c   = o_c;
            held.ovf = o_ovf;
            held.tag = o_tag;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                          input logic sub, input logic [3:0] tag);
        i_a   = a;
        i_b   = b;
        i_c   = c;
        i_sub = sub;
        i_tag = tag;
    endtask

    // Presents one op and returns after the edge that accepts it (i_valid left high).
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic sub, input logic [3:0] tag);
        bit done;
        done    = 1'b0;
        i_valid = 1'b1;
        set_op(a, b, c, sub, tag);
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            done = o_ready;
            tick();
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int w = 0; w < 50 && q.size() != 0; w++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(o_valid), 64'd0);
    endtask

    task automatic latency_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                              input logic sub, input logic [3:0] tag);
        i_valid = 1'b1;
        set_op(a, b, c, sub, tag);
        @(negedge clk);
        chk("lat_ready", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        for (int e = 1; e <= ST; e++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_e%0d", e), 64'(o_valid), 64'(e == ST));
        end
        tick();
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic sub, input logic [3:0] tag);
        res_t e;
        e    = ref_op({56'd0, a}, {56'd0, b}, c, sub, tag, 8);
        a8   = a;
        b8   = b;
        c8   = c;
        sub8 = sub;
        tag8 = tag;
        v8   = 1'b1;
        @(negedge clk);
        chk("s1_ready", 64'(rdy_s1), 64'd1);
        chk("s8_ready", 64'(rdy_s8), 64'd1);
        tick();
        v8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("s1_valid_e%0d", k), 64'(vld_s1), 64'(k == 1));
            chk($sformatf("s8_valid_e%0d", k), 64'(vld_s8), 64'(k == 8));
            if (k == 1) begin
                chk("s1_s", 64'(s_s1), e.s);
                chk("s1_c", 64'(c_s1), 64'(e.c));
                chk("s1_ovf", 64'(ovf_s1), 64'(e.ovf));
                chk("s1_tag", 64'(tag_s1), 64'(e.tag));
            end
            if (k == 8) begin
                chk("s8_s", 64'(s_s8), e.s);
                chk("s8_c", 64'(c_s8), 64'(e.c));
                chk("s8_ovf", 64'(ovf_s8), 64'(e.ovf));
                chk("s8_tag", 64'(tag_s8), 64'(e.tag));
            end
        end
        tick();
    endtask

    initial begin
        int  p0;
        int  acc;
        bit  took;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        set_op(64'd0, 64'd0, 1'b0, 1'b0, 4'd0);
        v8 = 1'b0; rdy8 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0; tag8 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_s", o_s, 64'd0);
        chk("rst_c", 64'(o_c), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_s1_valid", 64'(vld_s1), 64'd0);
        chk("rst_s8_valid", 64'(vld_s8), 64'd0);
        tick();

        latency_op(64'd5, 64'd7, 1'b0, 1'b0, 4'd3);

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd2);
        drain();
        send(64'd3, 64'd5, 1'b0, 1'b1, 4'd4);
        send(64'd10, 64'd4, 1'b1, 1'b1, 4'd5);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++)
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
                 1'($urandom()), 4'($urandom()));
        i_valid = 1'b0;
        rnd_rdy = 1'b0;
        tick();
        drain();

        // Full throughput with a never-stalling consumer.
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            i_valid = 1'b1;
            set_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
                   1'($urandom()), 4'(i));
            @(negedge clk);
            chk("tput_ready", 64'(o_ready), 64'd1);
            tick();
        end
        i_valid = 1'b0;
        repeat (4) tick();
        chk("tput_results", 64'(n_pop - p0), 64'd20);
        drain();

        // Fill with the consumer stalled, then release it for a single cycle.
        i_ready = 1'b0;
        i_valid = 1'b1;
        acc     = 0;
        set_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            took = o_ready;
            tick();
            if (took) begin
                acc++;
                set_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
                       1'($urandom()), 4'(acc));
            end
        end
        chk("fill_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        chk("fill_ready", 64'(o_ready), 64'd0);
        p0 = n_pop;
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(o_ready), 64'd1);
        chk("release_valid", 64'(o_valid), 64'd1);
        tick();
        i_ready = 1'b0;
        set_op(64'd77, 64'd1, 1'b0, 1'b0, 4'd9);
        @(negedge clk);
        chk("release_one_out", 64'(n_pop - p0), 64'd1);
        chk("refill_ready", 64'(o_ready), 64'd0);
        tick();
        drain();

        // Reset with three ops in flight and an op offered during reset.
        send(64'd1, 64'd2, 1'b0, 1'b0, 4'd1);
        send(64'd3, 64'd4, 1'b0, 1'b0, 4'd2);
        send(64'd5, 64'd6, 1'b0, 1'b0, 4'd3);
        rst = 1'b1;
        set_op(64'd100, 64'd1, 1'b0, 1'b0, 4'd7);
        tick();
        rst     = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_s", o_s, 64'd0);
        chk("midrst_tag", 64'(o_tag), 64'd0);
        repeat (8) tick();
        latency_op(64'd9, 64'd9, 1'b0, 1'b0, 4'd6);
        drain();

        run8(8'd5, 8'd7, 1'b0, 1'b0, 4'd3);
        run8(8'hFF, 8'd1, 1'b0, 1'b0, 4'd1);
        run8(8'h7F, 8'd1, 1'b0, 1'b0, 4'd2);
        run8(8'd3, 8'd5, 1'b0, 1'b1, 4'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
